// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS-6 constants, checker states and generator recurrence
package prbs_pkg;

  localparam int PRBS_N        = 6;
  localparam int PRBS_LOCK_CNT = 4;
  localparam int PRBS_LOSS_CNT = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // x^6+x^5+1: feedback from bits 5 and 4 shifts in at the LSB
  function automatic logic [PRBS_N-1:0] prbs_next(input logic [PRBS_N-1:0] w);
    return {w[PRBS_N-2:0], w[5] ^ w[4]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // a clear coinciding with an increment keeps that one event
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS-6 stream checker with hunt/lock tracking and error counting
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int N        = PRBS_N,
  parameter int LOCK_CNT = PRBS_LOCK_CNT,
  parameter int LOSS_CNT = PRBS_LOSS_CNT
) (
  input  logic         clock,
  input  logic         new_Game,
  input  logic         in_valid,
  input  logic [N-1:0] prbs_in,
  input  logic         clr_cnt,
  output logic         locked,
  output logic         err_pulse,
  output logic [7:0]   err_count,
  output logic [N-1:0] exp_word
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  prbs_state_t   r_state;
  logic [MW-1:0] r_match_cnt;
  logic [LW-1:0] r_miss_cnt;
  logic [N-1:0]  r_exp;
  logic          r_locked;
  logic          r_err;

  logic w_match;
  logic w_err;

  assign w_match = (prbs_in == r_exp);
  assign w_err   = in_valid && (r_state == LOCKED) && !w_match;

  always_ff @(posedge clock or posedge new_Game) begin
    if (new_Game) begin
      r_state     <= HUNT;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_exp       <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_err;
      if (in_valid) begin
        case (r_state)
          HUNT: begin
            r_exp <= prbs_next(prbs_in);
            // zero words can never seed a lock
            if (w_match && (prbs_in != '0)) begin
              if (r_match_cnt == MW'(LOCK_CNT - 1)) begin
                r_state     <= LOCKED;
                r_locked    <= 1'b1;
                r_match_cnt <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + MW'(1);
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_miss_cnt <= '0;
              r_exp      <= prbs_next(r_exp);
            end else if (r_miss_cnt == LW'(LOSS_CNT - 1)) begin
              r_state     <= HUNT;
              r_locked    <= 1'b0;
              r_miss_cnt  <= '0;
              r_match_cnt <= '0;
              r_exp       <= prbs_next(prbs_in);
            end else begin
              // free-run the local generator so one bad word costs one error
              r_miss_cnt <= r_miss_cnt + LW'(1);
              r_exp      <= prbs_next(r_exp);
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  sat_counter #(
    .W(8)
  ) u_err_cnt (
    .i_clk   (clock),
    .i_rst   (new_Game),
    .i_clr   (clr_cnt),
    .i_inc   (w_err),
    .o_count (err_count)
  );

  assign locked    = r_locked;
  assign err_pulse = r_err;
  assign exp_word  = r_exp;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker against a behavioural model
module tb_prbs_checker;

  localparam int NW   = 6;
  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic          clock;
  logic          new_Game;
  logic          in_valid;
  logic [NW-1:0] prbs_in;
  logic          clr_cnt;
  logic          locked;
  logic          err_pulse;
  logic [7:0]    err_count;
  logic [NW-1:0] exp_word;

  int  checks   = 0;
  int  failures = 0;
  bit  cmp_en   = 0;

  prbs_checker #(
    .N        (NW),
    .LOCK_CNT (LOCK),
    .LOSS_CNT (LOSS)
  ) dut (
    .clock     (clock),
    .new_Game  (new_Game),
    .in_valid  (in_valid),
    .prbs_in   (prbs_in),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .exp_word  (exp_word)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit            lk;
    int            match;
    int            miss;
    logic [NW-1:0] exp;
    int            cnt;
    bit            pulse;
  } mdl_t;

  function automatic logic [NW-1:0] gnext(input logic [NW-1:0] w);
    int x;
    x = int'(w);
    return NW'(((x * 2) & 63) | (((x >> 5) ^ (x >> 4)) & 1));
  endfunction

  function automatic mdl_t mreset();
    mdl_t s;
    s.lk = 0; s.match = 0; s.miss = 0; s.exp = '0; s.cnt = 0; s.pulse = 0;
    return s;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input bit v, input logic [NW-1:0] w, input bit c);
    mdl_t n;
    bit   e;
    n = s;
    e = 0;
    if (v) begin
      if (!s.lk) begin
        n.match = ((w == s.exp) && (w != 0)) ? s.match + 1 : 0;
        n.exp   = gnext(w);
        if (n.match == LOCK) begin
          n.lk    = 1;
          n.match = 0;
        end
      end else if (w == s.exp) begin
        n.miss = 0;
        n.exp  = gnext(s.exp);
      end else begin
        e      = 1;
        n.miss = s.miss + 1;
        n.exp  = gnext(s.exp);
        if (n.miss == LOSS) begin
          n.lk    = 0;
          n.miss  = 0;
          n.match = 0;
          n.exp   = gnext(w);
        end
      end
    end
    n.pulse = e;
    if (c)                     n.cnt = e ? 1 : 0;
    else if (e && s.cnt < 255) n.cnt = s.cnt + 1;
    return n;
  endfunction

  mdl_t m;

  always @(posedge clock or posedge new_Game) begin
    if (new_Game) m <= mreset();
    else          m <= mstep(m, in_valid, prbs_in, clr_cnt);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("mdl_locked",    32'(locked),    32'(m.lk));
      chk("mdl_err_pulse", 32'(err_pulse), 32'(m.pulse));
      chk("mdl_err_count", 32'(err_count), 32'(m.cnt));
      chk("mdl_exp_word",  32'(exp_word),  32'(m.exp));
    end
  end

  logic [NW-1:0] g;
  logic [NW-1:0] prev;

  task automatic feed(input bit v, input logic [NW-1:0] w, input bit c);
    in_valid = v;
    prbs_in  = w;
    clr_cnt  = c;
    @(posedge clock);
    #1;
    in_valid = 0;
    clr_cnt  = 0;
  endtask

  task automatic lock_from(input logic [NW-1:0] seed);
    g = seed;
    repeat (5) begin
      feed(1, g, 0);
      g = gnext(g);
    end
  endtask

  initial begin
    in_valid = 0; prbs_in = '0; clr_cnt = 0; new_Game = 0;
    #2 new_Game = 1;
    repeat (3) @(posedge clock);
    #1;
    cmp_en = 1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_exp_word", 32'(exp_word), 0);
    new_Game = 0;

    g = 6'b000001;
    repeat (5) begin
      feed(1, g, 0);
      g = gnext(g);
    end
    chk("lock_locked", 32'(locked), 1);
    chk("lock_exp_word", 32'(exp_word), 32'(6'b100001));
    chk("lock_err_count", 32'(err_count), 0);

    feed(1, g, 0);
    g = gnext(g);
    chk("seq_exp_000011", 32'(exp_word), 32'(6'b000011));
    feed(1, 6'b000000, 0);
    g = gnext(g);
    chk("one_err_pulse", 32'(err_pulse), 1);
    chk("one_err_count", 32'(err_count), 1);
    feed(1, g, 0);
    g = gnext(g);
    chk("one_err_pulse_end", 32'(err_pulse), 0);
    chk("one_err_locked", 32'(locked), 1);
    chk("one_err_exp", 32'(exp_word), 32'(6'b001100));

    feed(0, '0, 1);
    chk("clr_idle", 32'(err_count), 0);
    repeat (3) begin
      feed(1, g ^ 6'h3f, 0);
      g = gnext(g);
    end
    chk("loss_err_count", 32'(err_count), 3);
    chk("loss_locked", 32'(locked), 0);

    feed(0, '0, 1);
    repeat (20) feed(1, 6'b000000, 0);
    chk("zero_locked", 32'(locked), 0);
    chk("zero_err_count", 32'(err_count), 0);

    lock_from(6'h15);
    chk("gap_pre_locked", 32'(locked), 1);
    chk("gap_pre_exp", 32'(exp_word), 32'(g));
    repeat (5) feed(0, NW'($urandom), 0);
    chk("gap_locked", 32'(locked), 1);
    chk("gap_exp", 32'(exp_word), 32'(g));
    chk("gap_err_pulse", 32'(err_pulse), 0);

    feed(1, 6'h00, 0);
    g = gnext(g);
    @(posedge clock);
    #3 new_Game = 1;
    #1;
    chk("async_locked", 32'(locked), 0);
    chk("async_err_pulse", 32'(err_pulse), 0);
    chk("async_err_count", 32'(err_count), 0);
    chk("async_exp_word", 32'(exp_word), 0);
    @(posedge clock);
    #1 new_Game = 0;
    repeat (4) begin
      feed(1, g, 0);
      g = gnext(g);
    end
    chk("relock_4_locked", 32'(locked), 0);
    feed(1, g, 0);
    g = gnext(g);
    chk("relock_5_locked", 32'(locked), 1);

    repeat (3) begin
      feed(1, g ^ 6'h3f, 0);
      g = gnext(g);
    end
    for (int r = 0; r < 100; r++) begin
      lock_from(NW'($urandom_range(1, 63)));
      repeat (3) begin
        feed(1, g ^ 6'h3f, 0);
        g = gnext(g);
      end
    end
    chk("sat_err_count", 32'(err_count), 255);
    chk("sat_locked", 32'(locked), 0);
    lock_from(NW'($urandom_range(1, 63)));
    feed(1, g ^ 6'h01, 1);
    g = gnext(g);
    chk("clr_err_count", 32'(err_count), 1);
    chk("clr_err_pulse", 32'(err_pulse), 1);

    prev = g;
    for (int i = 0; i < 3000; i++) begin
      int            r;
      bit            v;
      bit            c;
      logic [NW-1:0] w;
      r = int'($urandom % 100);
      v = ($urandom % 4) != 0;
      c = ($urandom % 50) == 0;
      if (!v) begin
        feed(0, NW'($urandom), c);
      end else begin
        if (r < 84)      w = g;
        else if (r < 91) w = g ^ NW'($urandom_range(1, 63));
        else if (r < 95) w = prev;
        else if (r < 98) w = '0;
        else begin
          g = NW'($urandom_range(1, 63));
          w = g;
        end
        feed(1, w, c);
        prev = w;
        g    = gnext(g);
      end
    end

    repeat (2) feed(0, '0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter N, default 6: word width of the PRBS stream (polynomial x^6+x^5+1).
REQ-002 SHALL have parameter LOCK_CNT, default 4: consecutive predicted matches needed to lock.
REQ-003 SHALL have parameter LOSS_CNT, default 3: consecutive mismatches while locked needed to drop lock.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port new_Game  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  prbs_in holds a word this cycle.
REQ-007 SHALL have port prbs_in  input  N  received PRBS word.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of err_count.
REQ-009 SHALL have port locked  output  1  checker is synchronized to the stream.
REQ-010 SHALL have port err_pulse  output  1  one-cycle flag for a mismatched word while locked.
REQ-011 SHALL have port err_count  output  8  saturating error count.
REQ-012 SHALL have port exp_word  output  N  next word the checker expects.

Function
REQ-013 SHALL define next(w) = {w[N-2:0], w[5]^w[4]}, the generator's shift recurrence.
REQ-014 SHALL implement states HUNT and LOCKED; all state changes occur only on cycles with in_valid=1.
REQ-015 HUNT, valid word: if prbs_in == exp_word and prbs_in != 0, increment match counter; otherwise clear match counter; always load exp_word <= next(prbs_in).
REQ-016 HUNT: when the match counter reaches LOCK_CNT, SHALL enter LOCKED and set locked=1 on the next clock edge.
REQ-017 HUNT SHALL never assert err_pulse or change err_count.
REQ-018 All-zero words SHALL never count as matches, so an all-zero stream never locks.
REQ-019 LOCKED, valid word: exp_word <= next(exp_word), regardless of the input, so a single bad word gives exactly one error.
REQ-020 LOCKED, valid word with match: SHALL clear the miss counter.
REQ-021 LOCKED, valid word with mismatch: SHALL set err_pulse=1 for exactly the next cycle, increment err_count, and increment the miss counter.
REQ-022 LOCKED: when the miss counter reaches LOSS_CNT, SHALL enter HUNT, set locked=0, clear the match and miss counters, and load exp_word <= next(prbs_in).
REQ-023 All outputs SHALL be registered; latency from a sampled word to its err_pulse or locked change is exactly 1 clock.
REQ-024 err_count SHALL saturate at 255 and not wrap.
REQ-025 clr_cnt=1 SHALL set err_count to 0; if an error occurs in the same cycle, err_count SHALL become 1.
REQ-026 in_valid=0 SHALL hold all state, counters and exp_word, and drive err_pulse=0.
REQ-027 A repeated word (generator seed-reload duplicate) SHALL be treated as an ordinary mismatch in HUNT and cause only re-hunt.

Reset
REQ-028 new_Game=1 SHALL asynchronously force state=HUNT, locked=0, err_pulse=0, err_count=0, exp_word=0 and both counters=0.
REQ-029 Reset asserted mid-LOCKED SHALL discard lock; relock requires LOCK_CNT fresh matches after release.

Structure
REQ-030 N, LOCK_CNT/LOSS_CNT defaults, the state encoding and the next() function SHALL live in a shared package, prbs_pkg, also usable by the generator.
REQ-031 The saturating error counter with clear SHALL be a sub-module named sat_counter; everything else SHALL be flat.

Verification
REQ-032 Reset, then valid words 000001,000010,000100,001000,010000 -> locked=1 on the cycle after 010000, exp_word=100001, err_count=0.
REQ-033 While locked, feed 000000 in place of 000011, then 000110 -> exactly one err_pulse, err_count=1, locked stays 1.
REQ-034 While locked, feed 3 consecutive wrong words -> err_count=3, locked=0 after the third, state HUNT.
REQ-035 Continuous all-zero input for 20 valid cycles -> locked stays 0, err_count=0.
REQ-036 Force 300 errors (with relocks in between) -> err_count=255; clr_cnt together with an error -> err_count=1.
REQ-037 Assert new_Game mid-LOCKED, between clock edges -> all outputs 0 immediately; gap in in_valid during lock -> no state change.
